// File: rtl/arduino_cmd_rx.sv
// arduino_cmd_rx: 8N1 UART receiver that decodes Arduino game commands into one-cycle pulses.
// Define ARDUINO_RX_PARITY_EN for 8E1 framing with an extra parity_err pulse.
module arduino_cmd_rx #(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       cin,
    input  logic       reset_n,
    input  logic       rx,
    output logic       p1_press,
    output logic       p2_press,
    output logic       start_req,
    output logic       clear_req,
    output logic       unknown_cmd,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       rx_busy
`ifdef ARDUINO_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef ARDUINO_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, PARITY} state_t;
    localparam state_t AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic            prev_q, line, tick;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d, byte_q, byte_d;
    logic            valid_q, valid_d, ferr_q, ferr_d;
`ifdef ARDUINO_RX_PARITY_EN
    logic            bad_q, bad_d, perr_q, perr_d;
`endif

    assign line = sync_q[1];
    assign tick = cnt_q == '0;

    always_ff @(posedge cin or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef ARDUINO_RX_PARITY_EN
            bad_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx};
            prev_q  <= line;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef ARDUINO_RX_PARITY_EN
            bad_q   <= bad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef ARDUINO_RX_PARITY_EN
        bad_d   = bad_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: if (prev_q && !line) begin
                state_d = START;
                cnt_d   = HALF;
            end
            START: if (tick) begin
                state_d = line ? IDLE : DATA;
                cnt_d   = FULL;
                idx_d   = '0;
            end
            DATA: if (tick) begin
                shift_d[idx_q] = line;
                cnt_d          = FULL;
                idx_d          = idx_q + 3'd1;
                state_d        = (idx_q == 3'd7) ? AFTER_DATA : DATA;
            end
`ifdef ARDUINO_RX_PARITY_EN
            PARITY: if (tick) begin
                bad_d   = ^{shift_q, line};
                cnt_d   = FULL;
                state_d = STOP;
            end
`endif
            STOP: if (tick) begin
                state_d = line ? IDLE : BREAK;
                ferr_d  = !line;
`ifdef ARDUINO_RX_PARITY_EN
                perr_d  = line && bad_q;
                valid_d = line && !bad_q;
`else
                valid_d = line;
`endif
                byte_d  = valid_d ? shift_q : byte_q;
            end
            BREAK: state_d = line ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    assign byte_valid  = valid_q;
    assign rx_byte     = byte_q;
    assign frame_err   = ferr_q;
    assign rx_busy     = state_q != IDLE;
    assign p1_press    = valid_q && byte_q == 8'h31;
    assign p2_press    = valid_q && byte_q == 8'h32;
    assign start_req   = valid_q && byte_q == 8'h53;
    assign clear_req   = valid_q && byte_q == 8'h52;
    assign unknown_cmd = valid_q && !(byte_q inside {8'h31, 8'h32, 8'h53, 8'h52});
`ifdef ARDUINO_RX_PARITY_EN
    assign parity_err  = perr_q;
`endif
endmodule

// File: tb/tb_arduino_cmd_rx.sv
// tb_arduino_cmd_rx: directed frames checked against a queue-based model of expected receive events.
module tb_arduino_cmd_rx;
    logic clk = 1'b0, reset_n, rx;
    logic p1_press, p2_press, start_req, clear_req, unknown_cmd, byte_valid, frame_err, rx_busy, perr_sig;
    logic [7:0] rx_byte;

    always #5 clk = ~clk;

    arduino_cmd_rx #(.CLKS_PER_BIT(16)) dut (
        .cin(clk), .reset_n(reset_n), .rx(rx),
        .p1_press(p1_press), .p2_press(p2_press), .start_req(start_req), .clear_req(clear_req),
        .unknown_cmd(unknown_cmd), .byte_valid(byte_valid), .rx_byte(rx_byte),
        .frame_err(frame_err), .rx_busy(rx_busy)
`ifdef ARDUINO_RX_PARITY_EN
        , .parity_err(perr_sig)
`endif
    );
`ifndef ARDUINO_RX_PARITY_EN
    assign perr_sig = 1'b0;
`endif

    typedef struct packed {logic [1:0] kind; logic [7:0] b;} ev_t;
    ev_t q[$];
    int checks = 0, errors = 0, cyc = 0, ev_cyc = 0, n_ferr = 0, n_perr = 0;
    int n_cmd[5] = '{0, 0, 0, 0, 0};
    logic [7:0] model_byte = 8'h00;

    function automatic logic [4:0] decode(input logic [7:0] b);
        return b == 8'h31 ? 5'b00001 : b == 8'h32 ? 5'b00010 :
               b == 8'h53 ? 5'b00100 : b == 8'h52 ? 5'b01000 : 5'b10000;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [4:0] cmd;
        logic [7:0] act, exp_v;
        ev_t e;
        if (reset_n) begin
            cmd = {unknown_cmd, clear_req, start_req, p2_press, p1_press};
            act = {byte_valid, frame_err, perr_sig, cmd};
            for (int i = 0; i < 5; i++) if (cmd[i]) n_cmd[i]++;
            if (frame_err) n_ferr++;
            if (perr_sig) n_perr++;
            if (act != 8'h00) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse got=%b want=none at cycle %0d", act, cyc);
                end else begin
                    e = q.pop_front();
                    ev_cyc = cyc;
                    exp_v = e.kind == 2'd0 ? {3'b100, decode(e.b)} :
                            e.kind == 2'd1 ? 8'b01000000 : 8'b00100000;
                    if (act !== exp_v) begin
                        errors++;
                        $display("FAIL event_pulses got=%b want=%b byte=%h", act, exp_v, e.b);
                    end
                    if (e.kind == 2'd0) model_byte = e.b;
                end
            end
            checks++;
            if (rx_byte !== model_byte) begin
                errors++;
                $display("FAIL rx_byte got=%h want=%h at cycle %0d", rx_byte, model_byte, cyc);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, a, e);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        int stop_cyc;
        ev_t e;
        e.b    = b;
        e.kind = !stop_bit ? 2'd1 : bad_par ? 2'd2 : 2'd0;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef ARDUINO_RX_PARITY_EN
        drive_bit(^b ^ bad_par);
`endif
        stop_cyc = cyc;
        drive_bit(stop_bit);
        checks++;
        if (q.size() != 0 || ev_cyc - stop_cyc < 8 || ev_cyc - stop_cyc > 13) begin
            errors++;
            $display("FAIL frame_%h pending=%0d latency=%0d want 8..13", b, q.size(), ev_cyc - stop_cyc);
            q.delete();
        end
    endtask

    initial begin
        rx = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {p1_press, p2_press, start_req, clear_req, unknown_cmd, byte_valid, frame_err, rx_busy}, 0);
        chk("reset_byte", rx_byte, 8'h00);
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_busy", rx_busy, 0);
        send(8'h31, 1'b1, 1'b0);
        chk("byte_31", rx_byte, 8'h31);
        chk("p1_once", n_cmd[0], 1);
        send(8'h32, 1'b1, 1'b0);
        send(8'h53, 1'b1, 1'b0);
        send(8'h52, 1'b1, 1'b0);
        chk("byte_52", rx_byte, 8'h52);
        drive_bit(1'b1);
        send(8'h41, 1'b1, 1'b0);
        chk("byte_41", rx_byte, 8'h41);
        chk("unknown_once", n_cmd[4], 1);
        send(8'h53, 1'b1, 1'b0);
        send(8'h31, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_busy", rx_busy, 0);
        send(8'h32, 1'b1, 1'b0);
        send(8'h52, 1'b0, 1'b0);
        repeat (24) @(posedge clk);
        #1;
        chk("break_busy", rx_busy, 1);
        chk("break_byte", rx_byte, 8'h32);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("break_exit", rx_busy, 0);
        chk("ferr_once", n_ferr, 1);
        send(8'h31, 1'b1, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h31 >> i));
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        reset_n = 1'b0;
        q.delete();
        model_byte = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_busy", rx_busy, 0);
        reset_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("midrst_byte", rx_byte, 8'h00);
        send(8'h32, 1'b1, 1'b0);
        chk("after_rst_32", rx_byte, 8'h32);
`ifdef ARDUINO_RX_PARITY_EN
        send(8'h31, 1'b1, 1'b1);
        chk("perr_once", n_perr, 1);
        chk("perr_byte", rx_byte, 8'h32);
`endif
        repeat (20) @(posedge clk);
        #1;
        chk("n_p1", n_cmd[0], 3);
        chk("n_p2", n_cmd[1], 3);
        chk("n_start", n_cmd[2], 2);
        chk("n_clear", n_cmd[3], 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
